// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control unit for the MIPS core.
//
// Sequences every instruction through FETCH / DECODE / EXEC / MEM / WB so that
// the instruction memory, ALU, data memory and register file can be shared
// across cycles. FETCH and MEM each last MEM_LAT cycles, timed by an internal
// wait counter. Also keeps a retired-instruction counter and a sticky flag
// that records any undecodable instruction.
//
// Parameters:
//   MEM_LAT  cycles per IM or DM access (>= 1)
//   CNT_W    width of the retired-instruction counter
//
// Ports:
//   clk_i         clock, rising edge
//   reset_i       asynchronous reset, active high
//   op_i          IR[31:26]
//   func_i        IR[5:0]
//   zero_i        ALU equality flag
//   ir_write_o    load IR (last FETCH cycle)
//   pc_write_o    update PC this cycle (once per instruction)
//   pc_src_o      0 pc+4, 1 branch target, 2 jump target, 3 rs
//   reg_write_o   register file write enable
//   reg_dst_o     0 rt, 1 rd, 2 $31
//   mem_to_reg_o  0 ALU, 1 DM, 2 pc+4
//   alu_src_o     0 rd2, 1 extender output
//   ext_op_o      0 zero-ext, 1 sign-ext, 2 lui (imm << 16)
//   alu_op_o      0 ADD, 1 SUB, 2 OR, 3 PASSB
//   mem_read_o    DM read in progress
//   mem_write_o   DM write strobe (single pulse)
//   state_o       current state encoding
//   retired_o     count of completed legal instructions (wraps)
//   illegal_o     sticky: undecodable instruction seen
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [5:0]       op_i,
    input  logic [5:0]       func_i,
    input  logic             zero_i,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             alu_src_o,
    output logic [1:0]       ext_op_o,
    output logic [1:0]       alu_op_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_o,
    output logic             illegal_o
);

    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_NOP   = 6'b000000;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t             stateQ, stateD;
    logic [WAIT_W-1:0]  waitQ, waitD;
    logic [CNT_W-1:0]   retiredQ, retiredD;
    logic               illegalQ, illegalD;

    logic isRType, isAddu, isSubu, isJr, isNop;
    logic isOri, isLui, isLw, isSw, isBeq, isJ, isJal, isLegal;

    logic [1:0] instPcSrc, instRegDst, instMemToReg, instExtOp, instAluOp;
    logic       instAluSrc;

    logic irWrite, pcWrite, regWrite, memRead, memWrite, retire;
    logic lastWait;

    // Instruction classification straight from the IR fields.
    always_comb begin
        isRType = (op_i == OP_RTYPE);
        isAddu  = isRType && (func_i == FN_ADDU);
        isSubu  = isRType && (func_i == FN_SUBU);
        isJr    = isRType && (func_i == FN_JR);
        isNop   = isRType && (func_i == FN_NOP);
        isOri   = (op_i == OP_ORI);
        isLui   = (op_i == OP_LUI);
        isLw    = (op_i == OP_LW);
        isSw    = (op_i == OP_SW);
        isBeq   = (op_i == OP_BEQ);
        isJ     = (op_i == OP_J);
        isJal   = (op_i == OP_JAL);
        isLegal = isAddu | isSubu | isJr | isNop | isOri | isLui |
                  isLw | isSw | isBeq | isJ | isJal;
    end

    // Per-instruction datapath selects; held constant from DECODE through WB
    // because the IR does not change once loaded. Illegal encodings get all 0.
    always_comb begin
        instPcSrc    = 2'd0;
        instRegDst   = 2'd0;
        instMemToReg = 2'd0;
        instAluSrc   = 1'b0;
        instExtOp    = 2'd0;
        instAluOp    = 2'd0;
        if (isJ || isJal) begin
            instPcSrc = 2'd2;
        end
        if (isJr) begin
            instPcSrc = 2'd3;
        end
        if (isBeq) begin
            instPcSrc = zero_i ? 2'd1 : 2'd0;
        end
        if (isAddu || isSubu) begin
            instRegDst = 2'd1;
        end
        if (isJal) begin
            instRegDst   = 2'd2;
            instMemToReg = 2'd2;
        end
        if (isLw) begin
            instMemToReg = 2'd1;
        end
        instAluSrc = isOri | isLui | isLw | isSw;
        if (isLui) begin
            instExtOp = 2'd2;
        end
        if (isLw || isSw) begin
            instExtOp = 2'd1;
        end
        if (isSubu || isBeq) begin
            instAluOp = 2'd1;
        end
        if (isOri) begin
            instAluOp = 2'd2;
        end
        if (isLui) begin
            instAluOp = 2'd3;
        end
    end

    // Next-state, wait counter and strobes. Every path back to FETCH carries
    // exactly one pc_write; retire marks that cycle for legal instructions.
    always_comb begin
        stateD       = stateQ;
        waitD        = waitQ;
        illegalD     = illegalQ;
        irWrite      = 1'b0;
        pcWrite      = 1'b0;
        regWrite     = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        retire       = 1'b0;
        pc_src_o     = 2'd0;
        reg_dst_o    = 2'd0;
        mem_to_reg_o = 2'd0;
        alu_src_o    = 1'b0;
        ext_op_o     = 2'd0;
        alu_op_o     = 2'd0;
        lastWait     = (waitQ == WAIT_LAST);

        if (stateQ inside {DECODE, EXEC, MEM, WB}) begin
            pc_src_o     = instPcSrc;
            reg_dst_o    = instRegDst;
            mem_to_reg_o = instMemToReg;
            alu_src_o    = instAluSrc;
            ext_op_o     = instExtOp;
            alu_op_o     = instAluOp;
        end

        case (stateQ)
            FETCH: begin
                if (lastWait) begin
                    irWrite = 1'b1;
                    waitD   = '0;
                    stateD  = DECODE;
                end else begin
                    waitD = waitQ + WAIT_W'(1);
                end
            end
            DECODE: begin
                if (isJ || isJal || isJr || isNop) begin
                    pcWrite  = 1'b1;
                    regWrite = isJal;
                    retire   = 1'b1;
                    stateD   = FETCH;
                end else if (!isLegal) begin
                    illegalD = 1'b1;
                    pcWrite  = 1'b1;
                    stateD   = FETCH;
                end else begin
                    stateD = EXEC;
                end
            end
            EXEC: begin
                if (isBeq) begin
                    pcWrite = 1'b1;
                    retire  = 1'b1;
                    stateD  = FETCH;
                end else if (isLw || isSw) begin
                    waitD  = '0;
                    stateD = MEM;
                end else begin
                    stateD = WB;
                end
            end
            MEM: begin
                memRead = isLw;
                if (lastWait) begin
                    waitD = '0;
                    if (isSw) begin
                        memWrite = 1'b1;
                        pcWrite  = 1'b1;
                        retire   = 1'b1;
                        stateD   = FETCH;
                    end else if (isLw) begin
                        stateD = WB;
                    end else begin
                        stateD = FETCH;
                    end
                end else begin
                    waitD = waitQ + WAIT_W'(1);
                end
            end
            WB: begin
                regWrite = 1'b1;
                pcWrite  = 1'b1;
                retire   = 1'b1;
                stateD   = FETCH;
            end
            default: begin
                waitD  = '0;
                stateD = FETCH;
            end
        endcase

        retiredD = retire ? (retiredQ + CNT_W'(1)) : retiredQ;
    end

    // All architectural state lives here; reset aborts any instruction in
    // flight without counting it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stateQ   <= FETCH;
            waitQ    <= '0;
            retiredQ <= '0;
            illegalQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            waitQ    <= waitD;
            retiredQ <= retiredD;
            illegalQ <= illegalD;
        end
    end

    // Strobes are gated by reset so nothing reaches the datapath while reset
    // is held, even in the FETCH cycle that would load the IR when MEM_LAT=1.
    always_comb begin
        ir_write_o  = irWrite  & ~reset_i;
        pc_write_o  = pcWrite  & ~reset_i;
        reg_write_o = regWrite & ~reset_i;
        mem_read_o  = memRead  & ~reset_i;
        mem_write_o = memWrite & ~reset_i;
        state_o     = stateQ;
        retired_o   = retiredQ;
        illegal_o   = illegalQ;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational controller and lets IM, ALU, DM and GRF be shared across cycles.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives all datapath strobes and mux selects.
- Memory access latency is a parameter. The block also keeps a retired-instruction counter and a sticky illegal-instruction flag.
- It sits beside the datapath. op/func come from the IR; zero comes from the ALU.

Parameters:
- MEM_LAT, 1, cycles per IM or DM access (≥1); FETCH and MEM each last MEM_LAT cycles.
- CNT_W, 32, width of the retired counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU equality flag
- ir_write  out  1  load IR
- pc_write  out  1  update PC this cycle
- pc_src  out  2  0 pc+4, 1 branch target, 2 {pc[31:28],addr,2'b00}, 3 rs
- reg_write  out  1  GRF write enable
- reg_dst  out  2  0 rt, 1 rd, 2 $31
- mem_to_reg  out  2  0 ALU, 1 DM, 2 pc+4
- alu_src  out  1  0 rd2, 1 ext_out
- ext_op  out  2  0 zero-ext, 1 sign-ext, 2 lui (imm<<16)
- alu_op  out  2  0 ADD, 1 SUB, 2 OR, 3 PASSB
- mem_read  out  1  DM read in progress
- mem_write  out  1  DM write strobe
- state  out  3  current state encoding
- retired  out  CNT_W  instructions completed
- illegal  out  1  sticky: undecodable instruction seen

Behaviour:
- Reset is asynchronous and active-high; there is one clock, clk.
- While reset is high:
  - state=FETCH(0), wait counter=0, retired=0, illegal=0.
  - All strobes are forced to 0: ir_write, pc_write, reg_write, mem_read, mem_write.
- The first FETCH cycle is the first edge after reset deasserts. Reset mid-instruction aborts it; nothing retires.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 are unreachable and go to FETCH.
- Outputs are combinational from state, op, func, zero and the wait counter. Selects are 0 in FETCH.
- Supported instructions:
  - addu (op 0, func 100001), subu (op 0, func 100011), jr (op 0, func 001000), nop (op 0, func 000000)
  - ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), j (000010), jal (000011)
- FETCH:
  - Stays MEM_LAT cycles, counted by the internal wait counter.
  - ir_write=1 only in the final cycle, then go to DECODE.
- DECODE (1 cycle):
  - j: pc_write=1, pc_src=2.
  - jal: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2.
  - jr: pc_write=1, pc_src=3.
  - nop: pc_write=1, pc_src=0.
  - Each of the four cases above retires and returns to FETCH.
  - Illegal op/func: illegal←1, pc_write=1, pc_src=0, no retire, go to FETCH.
  - All others go to EXEC.
- EXEC (1 cycle), with alu_src/ext_op/alu_op set per instruction:
  - addu: 0/x/ADD
  - subu: 0/x/SUB
  - ori: 1/0/OR
  - lui: 1/2/PASSB
  - lw and sw: 1/1/ADD
  - beq: 0/x/SUB
  - beq: pc_write=1, pc_src = zero ? 1 : 0, retire, go to FETCH.
  - lw and sw go to MEM; the rest go to WB.
- MEM:
  - Stays MEM_LAT cycles.
  - lw: mem_read=1 for all MEM cycles, then go to WB.
  - sw: mem_write=1 only in the last cycle (exactly one pulse). In that same cycle pc_write=1, pc_src=0, retire, go to FETCH.
- WB (1 cycle):
  - reg_write=1.
  - reg_dst: 1 for R-type, 0 otherwise.
  - mem_to_reg: 1 for lw, 0 otherwise.
  - pc_write=1, pc_src=0, retire, go to FETCH.
- Selects valid for the instruction are held from DECODE through WB.
- Latency with L=MEM_LAT:
  - j/jal/jr/nop: L+1
  - beq: L+2
  - ALU ops: L+3
  - sw: 2L+2
  - lw: 2L+3
- Retirement is the pc_write cycle of a legal instruction. retired increments on the following edge and wraps at 2^CNT_W.
- pc_write fires exactly once per instruction, illegal included.
- illegal clears only on reset.

Test Plan:
- MEM_LAT=1, addu: states 0,1,2,4. reg_write=1, reg_dst=1 in WB only. retired 0→1 after 4 cycles.
- MEM_LAT=3, lw: FETCH 3 cycles with ir_write only in the 3rd; MEM 3 cycles with mem_read=1; WB reg_write with mem_to_reg=1. Total 9 cycles.
- MEM_LAT=2, sw: mem_write high for exactly 1 cycle (last MEM cycle), coincident with pc_write; reg_write never asserts.
- beq: zero=1 gives pc_src=1; zero=0 gives pc_src=0. Both finish in EXEC; jal gives reg_dst=2, mem_to_reg=2, pc_src=2 in DECODE.
- op=111111: illegal→1, pc_write with pc_src=0, retired unchanged. A following addu retires normally while illegal stays 1.
- Reset asserted mid-MEM of sw: outputs drop to 0 asynchronously, no mem_write pulse, state=0, retired=0; CNT_W=4 wraps 15→0.
